// File: rtl/mmu_tlb.sv
// Dual-channel MIPS32 address translator backed by a shared, fully associative,
// dual-page TLB with CP0 TLBP/TLBR/TLBWI/TLBWR service and one cycle of latency.
module mmu_tlb #(
    parameter int TLB_ENTRIES = 16,
    parameter bit ENABLE_TLB  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2:0]                     config_k0,
    input  logic [31:0]                    entryhi,
    input  logic [31:0]                    entrylo0,
    input  logic [31:0]                    entrylo1,
    input  logic [$clog2(TLB_ENTRIES)-1:0] cp0_index,
    input  logic                           tlbp,
    input  logic                           tlbr,
    input  logic                           tlbwi,
    input  logic                           tlbwr,
    input  logic                           i_req,
    input  logic                           d_req,
    input  logic [31:0]                    i_vaddr,
    input  logic [31:0]                    d_vaddr,
    input  logic                           d_store,
    input  logic                           i_stall,
    input  logic                           d_stall,
    output logic                           i_valid,
    output logic                           d_valid,
    output logic [31:0]                    i_paddr,
    output logic [31:0]                    d_paddr,
    output logic                           i_cached,
    output logic                           d_cached,
    output logic                           i_refill,
    output logic                           d_refill,
    output logic                           i_invalid,
    output logic                           d_invalid,
    output logic                           d_modified,
    output logic                           tlbp_done,
    output logic                           tlbp_miss,
    output logic [$clog2(TLB_ENTRIES)-1:0] tlbp_index,
    output logic                           tlbr_done,
    output logic [31:0]                    tlbr_entryhi,
    output logic [31:0]                    tlbr_entrylo0,
    output logic [31:0]                    tlbr_entrylo1
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);

    typedef struct packed {
        logic [31:0] paddr;
        logic        cached;
        logic        refill;
        logic        invalid;
        logic        modified;
    } xlat_t;

    // Each page word is {pfn[19:0], c[2:0], d, v}; index 0 is the even page.
    logic [18:0] tlb_vpn2 [TLB_ENTRIES];
    logic [7:0]  tlb_asid [TLB_ENTRIES];
    logic        tlb_g    [TLB_ENTRIES];
    logic [24:0] tlb_page [TLB_ENTRIES][2];

    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] p_idx;
    logic             p_hit;
    xlat_t            i_res, d_res, i_q, d_q;
    logic             unused_bits;

    // Lowest matching index wins, so scan downward and let later hits override.
    function automatic void probe(input logic [18:0] vpn2, input logic [7:0] asid,
                                  output logic hit, output logic [IDX_W-1:0] idx);
        hit = 1'b0;
        idx = '0;
        for (int k = TLB_ENTRIES - 1; k >= 0; k--) begin
            if (tlb_vpn2[k] == vpn2 && (tlb_g[k] || tlb_asid[k] == asid)) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    endfunction

    function automatic xlat_t translate(input logic [31:0] va, input logic store);
        xlat_t            r;
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [24:0]      page;
        r = '0;
        if (va[31:30] == 2'b10) begin
            r.paddr  = {3'b000, va[28:0]};
            r.cached = ~va[29] && (config_k0 == 3'd3);
        end else if (!ENABLE_TLB) begin
            r.paddr  = va;
            r.cached = 1'b1;
        end else begin
            probe(va[31:13], entryhi[7:0], hit, idx);
            page = tlb_page[idx][va[12]];
            if (!hit) begin
                r.refill = 1'b1;
            end else begin
                r.paddr    = {page[24:5], va[11:0]};
                r.cached   = (page[4:2] == 3'd3);
                r.invalid  = ~page[0];
                r.modified = store & page[0] & ~page[1];
            end
        end
        return r;
    endfunction

    always_comb begin
        i_res  = translate(i_vaddr, 1'b0);
        d_res  = translate(d_vaddr, d_store);
        probe(entryhi[31:13], entryhi[7:0], p_hit, p_idx);
        wr_idx = tlbwi ? cp0_index : random_q;
    end

    // Writes land at the edge, so same-cycle lookups and probes see old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TLB_ENTRIES; k++) begin
                tlb_vpn2[k]    <= '0;
                tlb_asid[k]    <= '0;
                tlb_g[k]       <= 1'b0;
                tlb_page[k][0] <= '0;
                tlb_page[k][1] <= '0;
            end
        end else if (tlbwi || tlbwr) begin
            tlb_vpn2[wr_idx]    <= entryhi[31:13];
            tlb_asid[wr_idx]    <= entryhi[7:0];
            tlb_g[wr_idx]       <= entrylo0[0] & entrylo1[0];
            tlb_page[wr_idx][0] <= entrylo0[25:1];
            tlb_page[wr_idx][1] <= entrylo1[25:1];
        end
    end

    // Power-of-two depth makes the natural underflow the required wrap to the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_q <= IDX_W'(TLB_ENTRIES - 1);
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_valid <= 1'b0;
            i_q     <= '0;
            d_valid <= 1'b0;
            d_q     <= '0;
        end else begin
            if (!i_stall) begin
                i_valid <= i_req;
                i_q     <= i_req ? i_res : '0;
            end
            if (!d_stall) begin
                d_valid <= d_req;
                d_q     <= d_req ? d_res : '0;
            end
        end
    end

    // A write strobe suppresses probe/read in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlbp_done     <= 1'b0;
            tlbp_miss     <= 1'b0;
            tlbp_index    <= '0;
            tlbr_done     <= 1'b0;
            tlbr_entryhi  <= '0;
            tlbr_entrylo0 <= '0;
            tlbr_entrylo1 <= '0;
        end else begin
            tlbp_done <= 1'b0;
            tlbr_done <= 1'b0;
            if (!tlbwi && !tlbwr) begin
                if (tlbp) begin
                    tlbp_done  <= 1'b1;
                    tlbp_miss  <= ~p_hit;
                    tlbp_index <= p_hit ? p_idx : '0;
                end else if (tlbr) begin
                    tlbr_done     <= 1'b1;
                    tlbr_entryhi  <= {tlb_vpn2[cp0_index], 5'b0, tlb_asid[cp0_index]};
                    tlbr_entrylo0 <= {6'b0, tlb_page[cp0_index][0], tlb_g[cp0_index]};
                    tlbr_entrylo1 <= {6'b0, tlb_page[cp0_index][1], tlb_g[cp0_index]};
                end
            end
        end
    end

    assign i_paddr    = i_q.paddr;
    assign i_cached   = i_q.cached;
    assign i_refill   = i_q.refill;
    assign i_invalid  = i_q.invalid;
    assign d_paddr    = d_q.paddr;
    assign d_cached   = d_q.cached;
    assign d_refill   = d_q.refill;
    assign d_invalid  = d_q.invalid;
    assign d_modified = d_q.modified;

    assign unused_bits = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26], i_q.modified};

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: directed literal checks plus randomized traffic
// compared every cycle against a behavioural TLB model kept as raw CP0 words.
module tb_mmu_tlb;
    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic [2:0]  config_k0;
    logic [31:0] entryhi, entrylo0, entrylo1;
    logic [3:0]  cp0_index;
    logic        tlbp, tlbr, tlbwi, tlbwr;
    logic        i_req, d_req, d_store, i_stall, d_stall;
    logic [31:0] i_vaddr, d_vaddr;
    logic        i_valid, d_valid, i_cached, d_cached, i_refill, d_refill;
    logic        i_invalid, d_invalid, d_modified;
    logic [31:0] i_paddr, d_paddr;
    logic        tlbp_done, tlbp_miss, tlbr_done;
    logic [3:0]  tlbp_index;
    logic [31:0] tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    mmu_tlb #(.TLB_ENTRIES(N), .ENABLE_TLB(1'b1)) dut (
        .clk(clk), .rst(rst), .config_k0(config_k0),
        .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1),
        .cp0_index(cp0_index), .tlbp(tlbp), .tlbr(tlbr), .tlbwi(tlbwi), .tlbwr(tlbwr),
        .i_req(i_req), .d_req(d_req), .i_vaddr(i_vaddr), .d_vaddr(d_vaddr),
        .d_store(d_store), .i_stall(i_stall), .d_stall(d_stall),
        .i_valid(i_valid), .d_valid(d_valid), .i_paddr(i_paddr), .d_paddr(d_paddr),
        .i_cached(i_cached), .d_cached(d_cached), .i_refill(i_refill), .d_refill(d_refill),
        .i_invalid(i_invalid), .d_invalid(d_invalid), .d_modified(d_modified),
        .tlbp_done(tlbp_done), .tlbp_miss(tlbp_miss), .tlbp_index(tlbp_index),
        .tlbr_done(tlbr_done), .tlbr_entryhi(tlbr_entryhi),
        .tlbr_entrylo0(tlbr_entrylo0), .tlbr_entrylo1(tlbr_entrylo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: entries kept as masked CP0 words plus the combined global bit.
    logic [31:0] m_hi [N];
    logic [31:0] m_lo0 [N];
    logic [31:0] m_lo1 [N];
    logic        m_g [N];
    int          m_rnd;
    logic        e_i_valid, e_i_ca, e_i_rf, e_i_inv, e_i_mod;
    logic        e_d_valid, e_d_ca, e_d_rf, e_d_inv, e_d_mod;
    logic [31:0] e_i_pa, e_d_pa;
    logic        e_p_done, e_p_miss, e_r_done;
    int          e_p_idx;
    logic [31:0] e_r_hi, e_r_lo0, e_r_lo1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int mfind(input logic [18:0] vpn2, input logic [7:0] asid);
        for (int i = 0; i < N; i++) begin
            if (m_hi[i][31:13] == vpn2 && (m_g[i] || m_hi[i][7:0] == asid)) return i;
        end
        return -1;
    endfunction

    function automatic void mtranslate(input logic [31:0] va, input logic st,
                                       output logic [31:0] pa, output logic ca,
                                       output logic rf, output logic inv, output logic md);
        int          h;
        logic [31:0] lo;
        pa = 0; ca = 0; rf = 0; inv = 0; md = 0;
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
            pa = va & 32'h1FFF_FFFF;
            ca = (va[31:29] == 3'b100) && (config_k0 == 3'd3);
        end else begin
            h = mfind(va[31:13], entryhi[7:0]);
            if (h < 0) begin
                rf = 1;
            end else begin
                lo  = va[12] ? m_lo1[h] : m_lo0[h];
                pa  = {lo[25:6], va[11:0]};
                ca  = (lo[5:3] == 3'd3);
                inv = !lo[1];
                md  = st && lo[1] && !lo[2];
            end
        end
    endfunction

    function automatic void mwrite(input int k);
        m_hi[k]  = entryhi & 32'hFFFF_E0FF;
        m_lo0[k] = entrylo0 & 32'h03FF_FFFE;
        m_lo1[k] = entrylo1 & 32'h03FF_FFFE;
        m_g[k]   = entrylo0[0] & entrylo1[0];
    endfunction

    always @(posedge clk or posedge rst) begin
        int h;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0; m_g[i] = 0;
            end
            m_rnd = N - 1;
            {e_i_valid, e_i_ca, e_i_rf, e_i_inv, e_i_mod, e_i_pa} = '0;
            {e_d_valid, e_d_ca, e_d_rf, e_d_inv, e_d_mod, e_d_pa} = '0;
            e_p_done = 0; e_p_miss = 0; e_p_idx = 0;
            e_r_done = 0; e_r_hi = 0; e_r_lo0 = 0; e_r_lo1 = 0;
        end else begin
            if (!i_stall) begin
                e_i_valid = i_req;
                if (i_req) mtranslate(i_vaddr, 1'b0, e_i_pa, e_i_ca, e_i_rf, e_i_inv, e_i_mod);
            end
            if (!d_stall) begin
                e_d_valid = d_req;
                if (d_req) mtranslate(d_vaddr, d_store, e_d_pa, e_d_ca, e_d_rf, e_d_inv, e_d_mod);
            end
            e_p_done = 0;
            e_r_done = 0;
            if (tlbwi) mwrite(int'(cp0_index));
            else if (tlbwr) mwrite(m_rnd);
            else if (tlbp) begin
                h        = mfind(entryhi[31:13], entryhi[7:0]);
                e_p_done = 1;
                e_p_miss = (h < 0);
                e_p_idx  = (h < 0) ? 0 : h;
            end else if (tlbr) begin
                e_r_done = 1;
                e_r_hi   = m_hi[cp0_index];
                e_r_lo0  = m_lo0[cp0_index] | 32'(m_g[cp0_index]);
                e_r_lo1  = m_lo1[cp0_index] | 32'(m_g[cp0_index]);
            end
            m_rnd = (m_rnd == 0) ? N - 1 : m_rnd - 1;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on && !rst) begin
            checkOutput("m_i_valid", 32'(i_valid), 32'(e_i_valid));
            if (e_i_valid) begin
                checkOutput("m_i_paddr", i_paddr, e_i_pa);
                checkOutput("m_i_flags", {29'b0, i_cached, i_refill, i_invalid},
                            {29'b0, e_i_ca, e_i_rf, e_i_inv});
            end
            checkOutput("m_d_valid", 32'(d_valid), 32'(e_d_valid));
            if (e_d_valid) begin
                checkOutput("m_d_paddr", d_paddr, e_d_pa);
                checkOutput("m_d_flags", {28'b0, d_cached, d_refill, d_invalid, d_modified},
                            {28'b0, e_d_ca, e_d_rf, e_d_inv, e_d_mod});
            end
            checkOutput("m_tlbp_done", 32'(tlbp_done), 32'(e_p_done));
            if (e_p_done) begin
                checkOutput("m_tlbp_miss", 32'(tlbp_miss), 32'(e_p_miss));
                checkOutput("m_tlbp_index", 32'(tlbp_index), 32'(e_p_idx));
            end
            checkOutput("m_tlbr_done", 32'(tlbr_done), 32'(e_r_done));
            if (e_r_done) begin
                checkOutput("m_tlbr_hi", tlbr_entryhi, e_r_hi);
                checkOutput("m_tlbr_lo0", tlbr_entrylo0, e_r_lo0);
                checkOutput("m_tlbr_lo1", tlbr_entrylo1, e_r_lo1);
            end
        end
    end

    function automatic logic [31:0] randVaddr();
        return {3'($urandom_range(7)), 13'b0, 3'($urandom_range(7)),
                1'($urandom_range(1)), 12'($urandom)};
    endfunction

    initial begin
        rst = 1; config_k0 = 3; entryhi = 0; entrylo0 = 0; entrylo1 = 0; cp0_index = 0;
        tlbp = 0; tlbr = 0; tlbwi = 0; tlbwr = 0; i_req = 0; d_req = 0; d_store = 0;
        i_stall = 0; d_stall = 0; i_vaddr = 0; d_vaddr = 0;
        applyStimulus(3);
        checkOutput("reset_d_valid", 32'(d_valid), 0);
        checkOutput("reset_tlbp", {31'b0, tlbp_done}, 0);
        model_on = 1;
        rst = 0;

        // Random counter: TLBWR on the 4th edge after release lands in entry 12.
        applyStimulus(3);
        entryhi = 32'h0300_0033; entrylo0 = 32'h0000_0107; entrylo1 = 32'h0000_0143;
        tlbwr = 1; applyStimulus(1); tlbwr = 0;
        cp0_index = 12; tlbr = 1; applyStimulus(1); tlbr = 0;
        checkOutput("tlbwr_rand_hi", tlbr_entryhi, 32'h0300_0033);
        checkOutput("tlbwr_rand_lo0", tlbr_entrylo0, 32'h0000_0107);
        checkOutput("tlbwr_rand_lo1", tlbr_entrylo1, 32'h0000_0143);

        d_vaddr = 32'h8000_1234; d_req = 1; config_k0 = 3; applyStimulus(1);
        checkOutput("kseg0_paddr", d_paddr, 32'h0000_1234);
        checkOutput("kseg0_cached", 32'(d_cached), 1);
        config_k0 = 2; applyStimulus(1);
        checkOutput("kseg0_k0_2", 32'(d_cached), 0);
        d_vaddr = 32'hA000_0010; config_k0 = 3; applyStimulus(1);
        checkOutput("kseg1_paddr", d_paddr, 32'h0000_0010);
        checkOutput("kseg1_cached", 32'(d_cached), 0);
        d_req = 0; applyStimulus(1);
        checkOutput("idle_d_valid", 32'(d_valid), 0);

        entryhi = 32'h0040_0012; entrylo0 = 32'h007C_001E; entrylo1 = 32'h0000_0A90;
        cp0_index = 5; tlbwi = 1; applyStimulus(1); tlbwi = 0;
        i_vaddr = 32'h0040_0ABC; i_req = 1; applyStimulus(1);
        checkOutput("wi5_paddr", i_paddr, 32'h1F00_0ABC);
        checkOutput("wi5_flags", {29'b0, i_cached, i_refill, i_invalid}, 32'h4);
        entryhi = 32'h0040_0013; applyStimulus(1);
        checkOutput("asid_refill", {31'b0, i_refill}, 1);
        checkOutput("asid_paddr", i_paddr, 0);
        i_req = 0; entryhi = 32'h0040_0012;

        d_vaddr = 32'h0040_1000; d_req = 1; applyStimulus(1);
        checkOutput("odd_invalid", {30'b0, d_invalid, d_refill}, 32'h2);
        entryhi = 32'h0080_0012; entrylo0 = 32'h0000_48D2; entrylo1 = 0;
        cp0_index = 6; tlbwi = 1; applyStimulus(1); tlbwi = 0;
        d_vaddr = 32'h0080_0456; d_store = 1; applyStimulus(1);
        checkOutput("store_modified", 32'(d_modified), 1);
        checkOutput("store_paddr", d_paddr, 32'h0012_3456);
        d_store = 0; applyStimulus(1);
        checkOutput("load_flags", {28'b0, d_cached, d_refill, d_invalid, d_modified}, 0);

        entryhi = 32'h0040_0012; tlbp = 1; applyStimulus(1); tlbp = 0;
        checkOutput("tlbp_hit", {27'b0, tlbp_done, tlbp_miss, tlbp_index}, 32'h25);
        applyStimulus(1);
        checkOutput("tlbp_pulse", 32'(tlbp_done), 0);
        entryhi = 32'h00C0_0012; tlbp = 1; applyStimulus(1); tlbp = 0;
        checkOutput("tlbp_miss", {27'b0, tlbp_done, tlbp_miss, tlbp_index}, 32'h30);
        cp0_index = 5; tlbr = 1; applyStimulus(1); tlbr = 0;
        checkOutput("tlbr5_hi", tlbr_entryhi, 32'h0040_0012);
        checkOutput("tlbr5_lo0", tlbr_entrylo0, 32'h007C_001E);
        checkOutput("tlbr5_lo1", tlbr_entrylo1, 32'h0000_0A90);

        entryhi = 32'h0040_0012; d_vaddr = 32'h0040_0ABC; applyStimulus(1);
        d_stall = 1;
        for (int k = 0; k < 3; k++) begin
            d_vaddr = 32'h8000_0000 + 32'(k * 256);
            applyStimulus(1);
            checkOutput("stall_paddr", d_paddr, 32'h1F00_0ABC);
        end
        d_stall = 0; d_req = 0;

        entryhi = 32'h0200_0012; entrylo0 = 32'h0000_0846; entrylo1 = 0; cp0_index = 9;
        tlbwi = 1; i_vaddr = 32'h0200_0123; i_req = 1; applyStimulus(1); tlbwi = 0;
        checkOutput("wr_same_cycle", 32'(i_refill), 1);
        applyStimulus(1);
        checkOutput("wr_next_cycle", {i_paddr[30:0], i_refill}, {32'h0002_1123, 1'b0} >> 1 << 1 | 32'h0);
        checkOutput("wr_next_paddr", i_paddr, 32'h0002_1123);

        #3 rst = 1;
        #1;
        checkOutput("async_i_valid", 32'(i_valid), 0);
        checkOutput("async_paddr", i_paddr, 0);
        checkOutput("async_tlbr_hi", tlbr_entryhi, 0);
        applyStimulus(2);
        rst = 0; i_vaddr = 32'h0040_0ABC; entryhi = 32'h0040_0012;
        applyStimulus(1);
        checkOutput("post_reset_miss", 32'(i_refill), 1);

        for (int n = 0; n < 3000; n++) begin
            i_vaddr   = randVaddr();
            d_vaddr   = randVaddr();
            i_req     = ($urandom_range(3) != 0);
            d_req     = ($urandom_range(3) != 0);
            i_stall   = ($urandom_range(7) == 0);
            d_stall   = ($urandom_range(7) == 0);
            d_store   = 1'($urandom_range(1));
            entryhi   = {3'($urandom_range(7)), 13'b0, 3'($urandom_range(7)),
                         5'($urandom), 8'($urandom_range(3))};
            entrylo0  = $urandom;
            entrylo1  = $urandom;
            cp0_index = 4'($urandom);
            tlbwi     = ($urandom_range(11) == 0);
            tlbwr     = ($urandom_range(11) == 0);
            tlbp      = ($urandom_range(7) == 0);
            tlbr      = ($urandom_range(7) == 0);
            if ($urandom_range(31) == 0) config_k0 = 3'($urandom);
            applyStimulus(1);
        end
        tlbwi = 0; tlbwr = 0; tlbp = 0; tlbr = 0; i_req = 0; d_req = 0;
        applyStimulus(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
